hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline hazard controller for a 5-stage in-order core.
//   Detects load-use hazards, sequences branch flushes and freezes the
//   pipeline while the data memory is busy, with a stall watchdog.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   id_opcode, id_rs1/rs2    : instruction in ID (opcode and source fields)
//   ex_rd, ex_memread        : destination / load flag of instruction in EX
//   ex_branch_taken          : branch in EX resolved taken
//   mem_busy                 : data memory freeze request
//   stall_pc/ifid/idex       : hold PC, IF/ID, ID/EX
//   bubble_idex              : insert NOP into ID/EX
//   flush_ifid/idex          : invalidate IF/ID, ID/EX
//   state                    : FSM state (RUN=0, STALL=1, FLUSH=2)
//   stall_err                : sticky stall-watchdog flag
//   stall_cnt, flush_cnt     : performance counters
// Build option: define HAZARD_PERF_CNT_EN to include the performance
//   counters; otherwise stall_cnt/flush_cnt read as zero.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MAX_STALL    = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       state,
  output logic             stall_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned FCNT_W = 4;
  localparam int unsigned SCNT_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic                stall_err_q, stall_err_d;

  logic use_rs1, use_rs2, lu;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_opcode)
      OP_IMM, OP_LOAD: use_rs1 = 1'b1;
      OP_STORE, OP_BRANCH, OP_REG: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
    lu = ex_memread && (ex_rd != 5'd0) &&
         ((use_rs1 && (id_rs1 == ex_rd)) || (use_rs2 && (id_rs2 == ex_rd)));
  end

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    scnt_d      = '0;
    stall_err_d = stall_err_q | (scnt_q == SCNT_W'(MAX_STALL));

    case (state_q)
      // STALL with the freeze released decodes exactly like RUN, so both
      // share one branch; only the watchdog count depends on being in STALL.
      RUN, STALL: begin
        if (mem_busy) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
          state_d    = STALL;
          if (state_q == STALL) begin
            scnt_d = (scnt_q == SCNT_W'(MAX_STALL)) ? scnt_q : scnt_q + SCNT_W'(1);
          end
        end else if (ex_branch_taken) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
          if (lu) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (mem_busy) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
        end else begin
          flush_ifid = 1'b1;
          if (fcnt_q <= FCNT_W'(1)) begin
            state_d = RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
          end
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    endcase

    if (reset) begin
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      stall_idex  = 1'b0;
      bubble_idex = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      scnt_q      <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      scnt_q      <= scnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign state     = state_q;
  assign stall_err = stall_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_pc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_ifid && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl - directed bench for hazard_ctrl (FLUSH_CYCLES=3, MAX_STALL=8).
//   Inputs change 1 time unit after the rising edge; outputs are compared
//   at the following falling edge.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 16;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_NUL = 7'b0000000;

  // control vector: {stall_pc, stall_ifid, stall_idex, bubble_idex, flush_ifid, flush_idex}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110100;
  localparam logic [5:0] C_ST   = 6'b111000;
  localparam logic [5:0] C_BR   = 6'b000011;
  localparam logic [5:0] C_FI   = 6'b000010;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             ex_memread, ex_branch_taken, mem_busy;
  logic             stall_pc, stall_ifid, stall_idex, bubble_idex;
  logic             flush_ifid, flush_idex;
  logic [1:0]       state;
  logic             stall_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [5:0]       ctl;

  int unsigned      n_checks = 0;
  int unsigned      n_fail   = 0;
  logic [CNT_W-1:0] exp_sc   = '0;
  logic [CNT_W-1:0] exp_fc   = '0;
  logic             prev_rst = 1'b1;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .FLUSH_CYCLES(3),
    .MAX_STALL   (8),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_opcode      (id_opcode),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .ex_rd          (ex_rd),
    .ex_memread     (ex_memread),
    .ex_branch_taken(ex_branch_taken),
    .mem_busy       (mem_busy),
    .stall_pc       (stall_pc),
    .stall_ifid     (stall_ifid),
    .stall_idex     (stall_idex),
    .bubble_idex    (bubble_idex),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .state          (state),
    .stall_err      (stall_err),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  assign ctl = {stall_pc, stall_ifid, stall_idex, bubble_idex, flush_ifid, flush_idex};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic mb, input logic br, input logic mr,
                      input logic [4:0] rd, input logic [6:0] op,
                      input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    reset           = rst;
    mem_busy        = mb;
    ex_branch_taken = br;
    ex_memread      = mr;
    ex_rd           = rd;
    id_opcode       = op;
    id_rs1          = r1;
    id_rs2          = r2;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, OP_NUL, 5'd0, 5'd0);
  endtask

  task automatic expect_cyc(input string tag, input logic [5:0] e_ctl,
                            input logic [1:0] e_st, input logic e_err);
    chk({tag, " ctl"}, 16'(ctl), 16'(e_ctl));
    chk({tag, " state"}, 16'(state), 16'(e_st));
    chk({tag, " stall_err"}, 16'(stall_err), 16'(e_err));
    if (prev_rst) begin
      exp_sc = '0;
      exp_fc = '0;
    end
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, " stall_cnt"}, stall_cnt, exp_sc);
    chk({tag, " flush_cnt"}, flush_cnt, exp_fc);
`else
    chk({tag, " stall_cnt"}, stall_cnt, 16'd0);
    chk({tag, " flush_cnt"}, flush_cnt, 16'd0);
`endif
    if (e_ctl[5]) exp_sc = exp_sc + 16'd1;
    if (e_ctl[1]) exp_fc = exp_fc + 16'd1;
    prev_rst = reset;
  endtask

  initial begin
    reset           = 1'b1;
    mem_busy        = 1'b1;
    ex_branch_taken = 1'b1;
    ex_memread      = 1'b1;
    ex_rd           = 5'd5;
    id_opcode       = OP_R;
    id_rs1          = 5'd0;
    id_rs2          = 5'd5;

    // reset dominates every event input
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, OP_R, 5'd0, 5'd5); expect_cyc("reset", C_NONE, 2'd0, 1'b0);

    // load-use decode
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, OP_R, 5'd1, 5'd5);   expect_cyc("lu_rs2_r", C_LU, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd5, OP_R, 5'd1, 5'd5);   expect_cyc("lu_one_cycle", C_NONE, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, OP_I, 5'd7, 5'd0);   expect_cyc("lu_rs1_i", C_LU, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, OP_I, 5'd3, 5'd7);   expect_cyc("i_ignores_rs2", C_NONE, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, OP_LUI, 5'd5, 5'd5); expect_cyc("lui_no_src", C_NONE, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, OP_R, 5'd0, 5'd0);   expect_cyc("rd_zero", C_NONE, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd5, OP_R, 5'd5, 5'd5);   expect_cyc("not_load", C_NONE, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, OP_S, 5'd1, 5'd9);   expect_cyc("lu_rs2_store", C_LU, 2'd0, 1'b0);

    // branch flush, lu and branch ignored inside FLUSH
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, OP_S, 5'd1, 5'd9);   expect_cyc("br_over_lu", C_BR, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, OP_S, 5'd1, 5'd9);   expect_cyc("flush1_ignores", C_FI, 2'd2, 1'b0);
    idle();                                                 expect_cyc("flush2", C_FI, 2'd2, 1'b0);
    idle();                                                 expect_cyc("flush_done", C_NONE, 2'd0, 1'b0);

    // memory freeze during the second FLUSH cycle
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, OP_NUL, 5'd0, 5'd0); expect_cyc("br2", C_BR, 2'd0, 1'b0);
    idle();                                                 expect_cyc("fl_first", C_FI, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, OP_NUL, 5'd0, 5'd0); expect_cyc("fl_freeze", C_ST, 2'd2, 1'b0);
    end
    idle();                                                 expect_cyc("fl_resume", C_FI, 2'd2, 1'b0);
    idle();                                                 expect_cyc("fl_end", C_NONE, 2'd0, 1'b0);

    // stall watchdog: mem_busy for 12 cycles, branch and lu masked by freeze
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, OP_NUL, 5'd0, 5'd0); expect_cyc("mb_in_run", C_ST, 2'd0, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      step(1'b0, 1'b1, (k == 3), 1'b1, 5'd5, OP_R, 5'd5, 5'd5);
      expect_cyc("stall_hold", C_ST, 2'd1, (k >= 10));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, OP_R, 5'd5, 5'd5);   expect_cyc("stall_exit_lu", C_LU, 2'd1, 1'b1);
    idle();                                                 expect_cyc("err_sticky", C_NONE, 2'd0, 1'b1);

    // STALL releasing straight into a branch flush
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, OP_NUL, 5'd0, 5'd0); expect_cyc("mb_again", C_ST, 2'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, OP_NUL, 5'd0, 5'd0); expect_cyc("stall_to_br", C_BR, 2'd1, 1'b1);
    idle();                                                 expect_cyc("sb_fl1", C_FI, 2'd2, 1'b1);
    idle();                                                 expect_cyc("sb_fl2", C_FI, 2'd2, 1'b1);
    idle();                                                 expect_cyc("sb_done", C_NONE, 2'd0, 1'b1);

    // reset during the second FLUSH cycle
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, OP_NUL, 5'd0, 5'd0); expect_cyc("br3", C_BR, 2'd0, 1'b1);
    idle();                                                 expect_cyc("br3_fl1", C_FI, 2'd2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, OP_NUL, 5'd0, 5'd0); expect_cyc("rst_mid_flush", C_NONE, 2'd2, 1'b1);
    idle();                                                 expect_cyc("post_rst", C_NONE, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, OP_R, 5'd3, 5'd0);   expect_cyc("post_rst_lu", C_LU, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
